// File: rtl/keyseq_pkg.sv
// Shared types and constants for the keypad code-entry controller.
// Optional build macro KEYSEQ_BACKSPACE_EN is interpreted by key_sequence_ctrl.
package keyseq_pkg;

    localparam int KEY_W         = 5;
    localparam int NUM_KEYS      = 12;
    localparam int KEY_BACKSPACE = 11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ENTRY   = 3'd1,
        CHECK   = 3'd2,
        LOCKOUT = 3'd3
    } state_t;

    function automatic logic is_valid_key(input logic [KEY_W-1:0] code);
        return code < KEY_W'(NUM_KEYS);
    endfunction

endpackage

// File: rtl/keyseq_timer.sv
// Clearable up-counter with two selectable terminal counts; done is high during
// the last counted cycle (count == TERM-1) while enabled.
module keyseq_timer #(
    parameter int WIDTH  = 8,
    parameter int TERM_A = 2,
    parameter int TERM_B = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    input  logic sel_b,
    output logic done
);

    localparam logic [WIDTH-1:0] TC_A = WIDTH'(TERM_A - 1);
    localparam logic [WIDTH-1:0] TC_B = WIDTH'(TERM_B - 1);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + WIDTH'(1);
        end
    end

    assign done = enable && (count == (sel_b ? TC_B : TC_A));

endmodule

// File: rtl/key_sequence_ctrl.sv
// Keypad session controller: collects SEQ_LEN keys, checks them against target_seq,
// and handles inactivity timeout and failure lockout. Macro KEYSEQ_BACKSPACE_EN makes key L a backspace.
module key_sequence_ctrl
    import keyseq_pkg::*;
#(
    parameter int SEQ_LEN     = 4,
    parameter int TIMEOUT_CYC = 125000000,
    parameter int MAX_FAIL    = 3,
    parameter int LOCK_CYC    = 250000000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [KEY_W-1:0]         key_code,
    input  logic                     key_valid,
    input  logic [KEY_W*SEQ_LEN-1:0] target_seq,
    output logic [KEY_W*SEQ_LEN-1:0] entry_buf,
    output logic [3:0]               entry_cnt,
    output logic                     busy,
    output logic                     locked,
    output logic                     match,
    output logic                     fail,
    output logic                     timeout,
    output logic [2:0]               state
);

    localparam int MAX_CYC = (TIMEOUT_CYC > LOCK_CYC) ? TIMEOUT_CYC : LOCK_CYC;
    localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int FAIL_W  = $clog2(MAX_FAIL + 1);

    state_t              state_q;
    logic [FAIL_W-1:0]   fail_cnt;
    logic                key_ok;
    logic                in_entry;
    logic                in_lock;
    logic                tmr_enable;
    logic                tmr_clear;
    logic                tmr_done;

    assign in_entry   = (state_q == ENTRY);
    assign in_lock    = (state_q == LOCKOUT);
    assign key_ok     = key_valid && is_valid_key(key_code);
    assign tmr_enable = in_entry || in_lock;
    // One timer serves both phases; any accepted key, restart or expiry reloads it.
    assign tmr_clear  = !tmr_enable || tmr_done || (in_entry && (start || key_ok));
    assign state      = state_q;

    keyseq_timer #(
        .WIDTH  (TMR_W),
        .TERM_A (TIMEOUT_CYC),
        .TERM_B (LOCK_CYC)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (tmr_clear),
        .enable (tmr_enable),
        .sel_b  (in_lock),
        .done   (tmr_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            fail_cnt  <= '0;
            entry_buf <= '0;
            entry_cnt <= '0;
            busy      <= 1'b0;
            locked    <= 1'b0;
            match     <= 1'b0;
            fail      <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            match   <= 1'b0;
            fail    <= 1'b0;
            timeout <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= ENTRY;
                        busy      <= 1'b1;
                        entry_buf <= '0;
                        entry_cnt <= '0;
                    end
                end
                ENTRY: begin
                    if (start) begin
                        entry_buf <= '0;
                        entry_cnt <= '0;
`ifdef KEYSEQ_BACKSPACE_EN
                    end else if (key_ok && key_code == KEY_W'(KEY_BACKSPACE)) begin
                        if (entry_cnt != 4'd0) begin
                            entry_cnt <= entry_cnt - 4'd1;
                            for (int k = 0; k < SEQ_LEN; k++) begin
                                if (4'(k) == entry_cnt - 4'd1) begin
                                    entry_buf[k*KEY_W +: KEY_W] <= '0;
                                end
                            end
                        end
`endif
                    end else if (key_ok) begin
                        for (int k = 0; k < SEQ_LEN; k++) begin
                            if (4'(k) == entry_cnt) begin
                                entry_buf[k*KEY_W +: KEY_W] <= key_code;
                            end
                        end
                        entry_cnt <= entry_cnt + 4'd1;
                        if (entry_cnt == 4'(SEQ_LEN - 1)) begin
                            state_q <= CHECK;
                        end
                    end else if (tmr_done) begin
                        state_q   <= IDLE;
                        busy      <= 1'b0;
                        timeout   <= 1'b1;
                        entry_buf <= '0;
                        entry_cnt <= '0;
                    end
                end
                CHECK: begin
                    busy <= 1'b0;
                    if (entry_buf == target_seq) begin
                        match    <= 1'b1;
                        fail_cnt <= '0;
                        state_q  <= IDLE;
                    end else begin
                        fail     <= 1'b1;
                        fail_cnt <= fail_cnt + FAIL_W'(1);
                        if (fail_cnt + FAIL_W'(1) == FAIL_W'(MAX_FAIL)) begin
                            state_q <= LOCKOUT;
                            locked  <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                LOCKOUT: begin
                    if (tmr_done) begin
                        state_q  <= IDLE;
                        locked   <= 1'b0;
                        fail_cnt <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                    locked  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_sequence_ctrl.sv
// Directed and randomized bench for key_sequence_ctrl against a queue-based session model.
// Honours KEYSEQ_BACKSPACE_EN the same way the design does.
module tb_key_sequence_ctrl;

    localparam int SEQ_LEN     = 4;
    localparam int TIMEOUT_CYC = 20;
    localparam int MAX_FAIL    = 2;
    localparam int LOCK_CYC    = 30;
    localparam int BUF_W       = 5 * SEQ_LEN;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             start     = 1'b0;
    logic [4:0]       key_code  = '0;
    logic             key_valid = 1'b0;
    logic [BUF_W-1:0] target_seq = {5'd4, 5'd11, 5'd0, 5'd2};
    logic [BUF_W-1:0] entry_buf;
    logic [3:0]       entry_cnt;
    logic             busy;
    logic             locked;
    logic             match;
    logic             fail;
    logic             timeout;
    logic [2:0]       state;

    int checks   = 0;
    int failures = 0;

    // Session model: keys held, phase flags, remaining lockout cycles, idle cycles.
    logic [4:0] m_keys[$];
    bit         m_session;
    bit         m_judging;
    int         m_lock_left;
    int         m_idle;
    int         m_fails;
    bit         m_match;
    bit         m_fail;
    bit         m_timeout;

    key_sequence_ctrl #(
        .SEQ_LEN     (SEQ_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .MAX_FAIL    (MAX_FAIL),
        .LOCK_CYC    (LOCK_CYC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .target_seq (target_seq),
        .entry_buf  (entry_buf),
        .entry_cnt  (entry_cnt),
        .busy       (busy),
        .locked     (locked),
        .match      (match),
        .fail       (fail),
        .timeout    (timeout),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_keys.delete();
        m_session   = 0;
        m_judging   = 0;
        m_lock_left = 0;
        m_idle      = 0;
        m_fails     = 0;
        m_match     = 0;
        m_fail      = 0;
        m_timeout   = 0;
    endtask

    function automatic bit keys_equal_target();
        if (m_keys.size() != SEQ_LEN) return 0;
        for (int i = 0; i < SEQ_LEN; i++) begin
            if (m_keys[i] != target_seq[i*5 +: 5]) return 0;
        end
        return 1;
    endfunction

    function automatic logic [BUF_W-1:0] exp_buf();
        logic [BUF_W-1:0] b;
        b = '0;
        foreach (m_keys[i]) b[i*5 +: 5] = m_keys[i];
        return b;
    endfunction

    function automatic logic [2:0] exp_state();
        if (m_lock_left > 0) return 3'd3;
        if (m_judging) return 3'd2;
        if (m_session) return 3'd1;
        return 3'd0;
    endfunction

    // Predicts the outputs after the coming clock edge from the inputs just driven.
    task automatic model_step();
        m_match   = 0;
        m_fail    = 0;
        m_timeout = 0;
        if (!rst_n) begin
            model_reset();
        end else if (m_lock_left > 0) begin
            m_lock_left--;
            if (m_lock_left == 0) m_fails = 0;
        end else if (m_judging) begin
            m_judging = 0;
            if (keys_equal_target()) begin
                m_match = 1;
                m_fails = 0;
            end else begin
                m_fail = 1;
                m_fails++;
                if (m_fails == MAX_FAIL) m_lock_left = LOCK_CYC;
            end
        end else if (m_session) begin
            if (start) begin
                m_keys.delete();
                m_idle = 0;
            end else if (key_valid && key_code < 5'd12) begin
                m_idle = 0;
`ifdef KEYSEQ_BACKSPACE_EN
                if (key_code == 5'd11) begin
                    if (m_keys.size() > 0) void'(m_keys.pop_back());
                end else
`endif
                begin
                    m_keys.push_back(key_code);
                    if (m_keys.size() == SEQ_LEN) begin
                        m_session = 0;
                        m_judging = 1;
                    end
                end
            end else begin
                m_idle++;
                if (m_idle == TIMEOUT_CYC) begin
                    m_session = 0;
                    m_timeout = 1;
                    m_keys.delete();
                end
            end
        end else if (start) begin
            m_session = 1;
            m_keys.delete();
            m_idle = 0;
        end
    endtask

    task automatic check_output();
        check_val("state",     32'(state),     32'(exp_state()));
        check_val("entry_cnt", 32'(entry_cnt), m_keys.size());
        check_val("entry_buf", 32'(entry_buf), 32'(exp_buf()));
        check_val("busy",      32'(busy),      32'(m_session || m_judging));
        check_val("locked",    32'(locked),    32'(m_lock_left > 0));
        check_val("match",     32'(match),     32'(m_match));
        check_val("fail",      32'(fail),      32'(m_fail));
        check_val("timeout",   32'(timeout),   32'(m_timeout));
    endtask

    task automatic apply_stimulus(input bit s, input bit v, input logic [4:0] c);
        @(negedge clk);
        check_output();
        start     = s;
        key_valid = v;
        key_code  = c;
        model_step();
    endtask

    task automatic idle(input int n);
        repeat (n) apply_stimulus(1'b0, 1'b0, 5'd0);
    endtask

    task automatic enter_seq(input logic [4:0] k0, input logic [4:0] k1,
                             input logic [4:0] k2, input logic [4:0] k3, input int gap);
        apply_stimulus(1'b1, 1'b0, 5'd0);
        apply_stimulus(1'b0, 1'b1, k0);
        idle(gap);
        apply_stimulus(1'b0, 1'b1, k1);
        idle(gap);
        apply_stimulus(1'b0, 1'b1, k2);
        idle(gap);
        apply_stimulus(1'b0, 1'b1, k3);
    endtask

    initial begin
        bit         s;
        bit         v;
        logic [4:0] c;

        model_reset();
        repeat (3) @(negedge clk);
        check_val("rst_state", 32'(state), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_buf", 32'(entry_buf), 32'd0);
        check_val("rst_cnt", 32'(entry_cnt), 32'd0);
        rst_n = 1'b1;
        idle(2);

`ifdef KEYSEQ_BACKSPACE_EN
        begin
            logic [4:0] bs_keys[5];
            int         bs_cnt[5];
            bs_keys = '{5'd2, 5'd0, 5'd11, 5'd11, 5'd0};
            bs_cnt  = '{1, 2, 1, 0, 1};
            apply_stimulus(1'b1, 1'b0, 5'd0);
            for (int i = 0; i < 5; i++) begin
                apply_stimulus(1'b0, 1'b1, bs_keys[i]);
                apply_stimulus(1'b0, 1'b0, 5'd0);
                check_val("bs_cnt", 32'(entry_cnt), bs_cnt[i]);
            end
            check_val("bs_buf", 32'(entry_buf), 32'd0);
            repeat (3) apply_stimulus(1'b0, 1'b1, 5'd4);
            apply_stimulus(1'b0, 1'b0, 5'd0);
            apply_stimulus(1'b0, 1'b0, 5'd0);
            check_val("bs_target_l_fails", 32'(fail), 32'd1);
            check_val("bs_no_match", 32'(match), 32'd0);
        end
`else
        $display("[TB] correct entry");
        enter_seq(5'd2, 5'd0, 5'd11, 5'd4, 4);
        apply_stimulus(1'b0, 1'b0, 5'd0);
        check_val("check_state", 32'(state), 32'd2);
        check_val("match_not_early", 32'(match), 32'd0);
        apply_stimulus(1'b0, 1'b0, 5'd0);
        check_val("match_pulse", 32'(match), 32'd1);
        check_val("match_buf", 32'(entry_buf), 32'({5'd4, 5'd11, 5'd0, 5'd2}));
        check_val("busy_after_match", 32'(busy), 32'd0);
        apply_stimulus(1'b0, 1'b0, 5'd0);
        check_val("match_one_cycle", 32'(match), 32'd0);
        check_val("cnt_persists", 32'(entry_cnt), 32'd4);

        $display("[TB] timeout");
        apply_stimulus(1'b1, 1'b0, 5'd0);
        apply_stimulus(1'b0, 1'b1, 5'd2);
        apply_stimulus(1'b0, 1'b1, 5'd0);
        idle(20);
        check_val("timeout_not_early", 32'(timeout), 32'd0);
        apply_stimulus(1'b0, 1'b0, 5'd0);
        check_val("timeout_pulse", 32'(timeout), 32'd1);
        check_val("timeout_state", 32'(state), 32'd0);
        check_val("timeout_no_fail", 32'(fail), 32'd0);
        apply_stimulus(1'b0, 1'b1, 5'd3);
        apply_stimulus(1'b0, 1'b0, 5'd0);
        check_val("idle_key_ignored", 32'(entry_cnt), 32'd0);

        $display("[TB] lockout");
        repeat (2) begin
            enter_seq(5'd1, 5'd1, 5'd1, 5'd1, 0);
            apply_stimulus(1'b0, 1'b0, 5'd0);
            apply_stimulus(1'b0, 1'b0, 5'd0);
            check_val("wrong_fail", 32'(fail), 32'd1);
        end
        check_val("locked_set", 32'(locked), 32'd1);
        check_val("lock_state", 32'(state), 32'd3);
        repeat (29) apply_stimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                   5'($urandom_range(0, 11)));
        check_val("lock_last_cycle", 32'(locked), 32'd1);
        apply_stimulus(1'b0, 1'b0, 5'd0);
        check_val("lock_release", 32'(locked), 32'd0);
        check_val("lock_release_state", 32'(state), 32'd0);
        enter_seq(5'd2, 5'd0, 5'd11, 5'd4, 1);
        idle(2);
        check_val("match_after_lock", 32'(match), 32'd1);

        $display("[TB] collision and restart");
        apply_stimulus(1'b1, 1'b0, 5'd0);
        apply_stimulus(1'b0, 1'b1, 5'd2);
        apply_stimulus(1'b0, 1'b1, 5'd0);
        apply_stimulus(1'b1, 1'b1, 5'd5);
        apply_stimulus(1'b0, 1'b0, 5'd0);
        check_val("collide_cnt", 32'(entry_cnt), 32'd0);
        check_val("collide_buf", 32'(entry_buf), 32'd0);
        check_val("collide_state", 32'(state), 32'd1);
        idle(18);
        apply_stimulus(1'b0, 1'b1, 5'd7);
        apply_stimulus(1'b0, 1'b0, 5'd0);
        check_val("expiry_key_no_timeout", 32'(timeout), 32'd0);
        check_val("expiry_key_cnt", 32'(entry_cnt), 32'd1);

        $display("[TB] invalid code and reset");
        apply_stimulus(1'b0, 1'b1, 5'd15);
        apply_stimulus(1'b0, 1'b0, 5'd0);
        check_val("invalid_dropped", 32'(entry_cnt), 32'd1);
        apply_stimulus(1'b0, 1'b1, 5'd3);
        apply_stimulus(1'b0, 1'b1, 5'd5);
        apply_stimulus(1'b0, 1'b0, 5'd0);
        check_val("three_keys", 32'(entry_cnt), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check_val("mid_rst_state", 32'(state), 32'd0);
        check_val("mid_rst_cnt", 32'(entry_cnt), 32'd0);
        check_val("mid_rst_buf", 32'(entry_buf), 32'd0);
        check_val("mid_rst_busy", 32'(busy), 32'd0);
        model_reset();
        apply_stimulus(1'b0, 1'b1, 5'd2);
        apply_stimulus(1'b0, 1'b1, 5'd4);
        @(negedge clk);
        rst_n     = 1'b1;
        key_valid = 1'b0;
        idle(4);
        check_val("post_rst_no_match", 32'(match), 32'd0);
        check_val("post_rst_no_fail", 32'(fail), 32'd0);
`endif

        $display("[TB] randomized traffic");
        for (int n = 0; n < 1500; n++) begin
            s = ($urandom_range(0, 39) == 0);
            v = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) != 0 && m_keys.size() < SEQ_LEN)
                c = target_seq[m_keys.size()*5 +: 5];
            else
                c = 5'($urandom_range(0, 15));
            apply_stimulus(s, v, c);
            if ($urandom_range(0, 99) == 0) idle(22);
        end
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
